// File: rtl/weight_tile_scheduler.sv
// weight_tile_scheduler
// Walks the weight loader over every Tn x Tm weight tile of one conv layer
// (m inner, n outer). For each tile it presents the tile base, pulses
// load_start, waits for load_done and then flags the tile as ready. A credit
// counter limits how many tiles may be loaded but not yet consumed, so the
// weight FIFO is never overfilled.
//
// Ports
//   clk            in   clock
//   rst            in   asynchronous, active-high reset
//   start          in   begin a layer sweep (honoured only in IDLE)
//   done           out  one-cycle pulse: all tiles loaded and consumed
//   busy           out  high in every state except IDLE
//   load_start     out  one-cycle start pulse to the weight loader
//   load_done      in   loader completion (honoured only in WAIT_LOAD)
//   tile_base_n    out  N base of the current tile
//   tile_base_m    out  M base of the current tile
//   tile_ready     out  one-cycle pulse: a tile is fully in the FIFO
//   tile_consumed  in   one-cycle pulse from compute: one tile released
//   tile_idx       out  0-based index of the current tile
//   credit_err     out  sticky: tile_consumed seen with credits already full
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for start; credits full
// ISSUE      | waiting for a free credit before starting the next load
// WAIT_LOAD  | loader running for the current tile
// DRAIN      | last tile loaded; waiting for all tiles to be consumed

module weight_tile_scheduler #(
  parameter int AW      = 32,
  parameter int N       = 32,
  parameter int M       = 32,
  parameter int Tn      = 8,
  parameter int Tm      = 8,
  parameter int MAX_OUT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          done,
  output logic          busy,
  output logic          load_start,
  input  logic          load_done,
  output logic [AW-1:0] tile_base_n,
  output logic [AW-1:0] tile_base_m,
  output logic          tile_ready,
  input  logic          tile_consumed,
  output logic [AW-1:0] tile_idx,
  output logic          credit_err
);

  localparam int TILES_N = (N + Tn - 1) / Tn;
  localparam int TILES_M = (M + Tm - 1) / Tm;
  localparam int TILES   = TILES_N * TILES_M;

  localparam logic [AW-1:0] LAST_IDX = AW'(TILES - 1);
  localparam logic [AW-1:0] TN_W     = AW'(Tn);
  localparam logic [AW-1:0] TM_W     = AW'(Tm);
  localparam logic [AW-1:0] M_W      = AW'(M);
  localparam logic [2:0]    CRED_MAX = 3'(MAX_OUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_LOAD,
    S_DRAIN
  } state_t;

  state_t        state_q;
  logic [2:0]    credits_q;
  logic [2:0]    credits_d;
  logic          issue_fire;
  logic          err_set;
  logic [AW-1:0] base_n_q;
  logic [AW-1:0] base_m_q;
  logic [AW-1:0] idx_q;
  logic [AW-1:0] m_sum;
  logic          done_q;
  logic          busy_q;
  logic          load_start_q;
  logic          tile_ready_q;
  logic          credit_err_q;

  // Credit bookkeeping: an issue and a consume in the same cycle cancel out.
  // A consume with credits already full is dropped and flagged.
  always_comb begin
    issue_fire = (state_q == S_ISSUE) && (credits_q != 3'd0);
    credits_d  = credits_q;
    err_set    = 1'b0;
    if (issue_fire && !tile_consumed) begin
      credits_d = credits_q - 3'd1;
    end else if (tile_consumed && !issue_fire) begin
      if (credits_q == CRED_MAX) begin
        err_set = 1'b1;
      end else begin
        credits_d = credits_q + 3'd1;
      end
    end
  end

  assign m_sum = base_m_q + TM_W;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      credits_q    <= CRED_MAX;
      base_n_q     <= '0;
      base_m_q     <= '0;
      idx_q        <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      load_start_q <= 1'b0;
      tile_ready_q <= 1'b0;
      credit_err_q <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      load_start_q <= 1'b0;
      tile_ready_q <= 1'b0;
      credits_q    <= credits_d;
      if (err_set) begin
        credit_err_q <= 1'b1;
      end
      case (state_q)
        // Credits are always full at start, so the first issue is taken on
        // the start edge itself; load_start then follows start by one cycle.
        S_IDLE: begin
          if (start) begin
            base_n_q     <= '0;
            base_m_q     <= '0;
            idx_q        <= '0;
            credit_err_q <= 1'b0;
            credits_q    <= CRED_MAX - 3'd1;
            load_start_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_WAIT_LOAD;
          end
        end
        S_ISSUE: begin
          if (issue_fire) begin
            load_start_q <= 1'b1;
            state_q      <= S_WAIT_LOAD;
          end
        end
        S_WAIT_LOAD: begin
          if (load_done) begin
            tile_ready_q <= 1'b1;
            if (idx_q == LAST_IDX) begin
              // bases stay on the final tile
              state_q <= S_DRAIN;
            end else begin
              if (m_sum >= M_W) begin
                base_m_q <= '0;
                base_n_q <= base_n_q + TN_W;
              end else begin
                base_m_q <= m_sum;
              end
              idx_q   <= idx_q + AW'(1);
              state_q <= S_ISSUE;
            end
          end
        end
        S_DRAIN: begin
          if (credits_q == CRED_MAX) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign done        = done_q;
  assign busy        = busy_q;
  assign load_start  = load_start_q;
  assign tile_ready  = tile_ready_q;
  assign credit_err  = credit_err_q;
  assign tile_base_n = base_n_q;
  assign tile_base_m = base_m_q;
  assign tile_idx    = idx_q;

endmodule

// File: tb/tb_weight_tile_scheduler.sv
// Directed bench for weight_tile_scheduler.
// dut0: N=M=32, Tn=Tm=8, MAX_OUT=2 (16 tiles)
// dut1: N=20, M=12, Tn=Tm=8, MAX_OUT=1 (6 tiles)

module tb_weight_tile_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start[2];
  logic        load_done[2];
  logic        tile_consumed[2];
  logic        done[2];
  logic        busy[2];
  logic        load_start[2];
  logic        tile_ready[2];
  logic        credit_err[2];
  logic [31:0] tile_base_n[2];
  logic [31:0] tile_base_m[2];
  logic [31:0] tile_idx[2];

  int n_checks = 0;
  int n_errors = 0;

  weight_tile_scheduler #(
    .AW(32), .N(32), .M(32), .Tn(8), .Tm(8), .MAX_OUT(2)
  ) dut0 (
    .clk           (clk),
    .rst           (rst),
    .start         (start[0]),
    .done          (done[0]),
    .busy          (busy[0]),
    .load_start    (load_start[0]),
    .load_done     (load_done[0]),
    .tile_base_n   (tile_base_n[0]),
    .tile_base_m   (tile_base_m[0]),
    .tile_ready    (tile_ready[0]),
    .tile_consumed (tile_consumed[0]),
    .tile_idx      (tile_idx[0]),
    .credit_err    (credit_err[0])
  );

  weight_tile_scheduler #(
    .AW(32), .N(20), .M(12), .Tn(8), .Tm(8), .MAX_OUT(1)
  ) dut1 (
    .clk           (clk),
    .rst           (rst),
    .start         (start[1]),
    .done          (done[1]),
    .busy          (busy[1]),
    .load_start    (load_start[1]),
    .load_done     (load_done[1]),
    .tile_base_n   (tile_base_n[1]),
    .tile_base_m   (tile_base_m[1]),
    .tile_ready    (tile_ready[1]),
    .tile_consumed (tile_consumed[1]),
    .tile_idx      (tile_idx[1]),
    .credit_err    (credit_err[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input int d, input string pfx);
    check({pfx, "_done"},       32'(done[d]),       0);
    check({pfx, "_busy"},       32'(busy[d]),       0);
    check({pfx, "_load_start"}, 32'(load_start[d]), 0);
    check({pfx, "_tile_ready"}, 32'(tile_ready[d]), 0);
    check({pfx, "_credit_err"}, 32'(credit_err[d]), 0);
    check({pfx, "_base_n"},     tile_base_n[d],     0);
    check({pfx, "_base_m"},     tile_base_m[d],     0);
    check({pfx, "_tile_idx"},   tile_idx[d],        0);
  endtask

  // Full sweep: loader answers 2 cycles after load_start, compute consumes
  // 3 cycles after each tile_ready.
  task automatic run_sweep(input int d, input int total, input int tiles_m,
                           input int tn, input int tm, input int max_out);
    int loads = 0;
    int readies = 0;
    int consumes = 0;
    int dones = 0;
    int cyc = 0;
    int ld_due = -1;
    int max_seen = 0;
    int extra = 0;
    int due[$];
    string pfx;
    pfx = $sformatf("sweep%0d", d);
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
    check({pfx, "_start_lat"},  32'(load_start[d]), 1);
    check({pfx, "_err_clear"},  32'(credit_err[d]), 0);
    check({pfx, "_busy"},       32'(busy[d]),       1);
    while (dones == 0 && cyc < 3000) begin
      if (load_start[d]) begin
        check($sformatf("%s_base_n_t%0d", pfx, loads), tile_base_n[d], 32'((loads / tiles_m) * tn));
        check($sformatf("%s_base_m_t%0d", pfx, loads), tile_base_m[d], 32'((loads % tiles_m) * tm));
        check($sformatf("%s_idx_t%0d", pfx, loads),    tile_idx[d],    32'(loads));
        loads++;
        ld_due = cyc + 2;
      end
      if (tile_ready[d]) begin
        readies++;
        due.push_back(cyc + 3);
      end
      if (done[d]) dones++;
      if (loads - consumes > max_seen) max_seen = loads - consumes;
      load_done[d] = (cyc == ld_due);
      tile_consumed[d] = 1'b0;
      if (due.size() > 0 && due[0] == cyc) begin
        void'(due.pop_front());
        tile_consumed[d] = 1'b1;
        consumes++;
      end
      tick();
      cyc++;
    end
    load_done[d] = 1'b0;
    tile_consumed[d] = 1'b0;
    check({pfx, "_done_seen"},   32'(dones),    1);
    check({pfx, "_loads"},       32'(loads),    32'(total));
    check({pfx, "_readies"},     32'(readies),  32'(total));
    check({pfx, "_max_out"},     32'(max_seen), 32'(max_out));
    check({pfx, "_busy_end"},    32'(busy[d]),  0);
    check({pfx, "_err_end"},     32'(credit_err[d]), 0);
    check({pfx, "_idx_end"},     tile_idx[d],    32'(total - 1));
    check({pfx, "_base_n_end"},  tile_base_n[d], 32'(((total - 1) / tiles_m) * tn));
    check({pfx, "_base_m_end"},  tile_base_m[d], 32'(((total - 1) % tiles_m) * tm));
    repeat (3) begin
      tick();
      if (done[d]) extra++;
    end
    check({pfx, "_done_once"}, 32'(extra), 0);
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      load_done[i] = 1'b0;
      tile_consumed[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_idle(0, "rst0");
    check_idle(1, "rst1");

    // consume with nothing outstanding: sticky error, credits stay full
    tile_consumed[0] = 1'b1;
    tick();
    tile_consumed[0] = 1'b0;
    check("spurious_err", 32'(credit_err[0]), 1);
    tick();
    check("spurious_err_sticky", 32'(credit_err[0]), 1);
    check("spurious_busy", 32'(busy[0]), 0);

    run_sweep(0, 16, 4, 8, 8, 2);
    run_sweep(1, 6, 2, 8, 8, 1);

    // MAX_OUT=1 stall, consume, same-cycle issue+consume, ignored start, async rst
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    check("s3_ls0", 32'(load_start[1]), 1);
    tick();
    tick();
    load_done[1] = 1'b1;
    tick();
    load_done[1] = 1'b0;
    check("s3_ready0", 32'(tile_ready[1]), 1);
    cnt = 0;
    repeat (8) begin
      tick();
      if (load_start[1]) cnt++;
    end
    check("s3_stall", 32'(cnt), 0);
    check("s3_stall_busy", 32'(busy[1]), 1);
    check("s3_stall_idx", tile_idx[1], 1);
    tile_consumed[1] = 1'b1;
    tick();
    check("s3_ls_not_yet", 32'(load_start[1]), 0);
    // issue happens on this edge; consume again in the same cycle
    tick();
    tile_consumed[1] = 1'b0;
    check("s3_ls1", 32'(load_start[1]), 1);
    check("s3_same_cycle_err", 32'(credit_err[1]), 0);
    tick();
    load_done[1] = 1'b1;
    tick();
    load_done[1] = 1'b0;
    check("s3_ready1", 32'(tile_ready[1]), 1);
    tick();
    check("s3_ls2_no_stall", 32'(load_start[1]), 1);
    check("s3_idx2", tile_idx[1], 2);
    check("s3_base_n2", tile_base_n[1], 8);
    check("s3_base_m2", tile_base_m[1], 0);
    check("s3_err2", 32'(credit_err[1]), 0);
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    check("s3_start_ignored_ls", 32'(load_start[1]), 0);
    check("s3_start_ignored_idx", tile_idx[1], 2);
    check("s3_start_ignored_busy", 32'(busy[1]), 1);
    #2;
    rst = 1'b1;
    #1;
    check_idle(1, "s3_rst");
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_idle(1, "s3_post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
